// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and helpers for the multi-cycle multiply/divide unit.
package muldiv_unit_pkg;

  // Opcodes as presented by execute.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Unit sequencing states.
  typedef enum logic [1:0] {
    MD_S_IDLE = 2'b00,
    MD_S_MUL  = 2'b01,
    MD_S_DIV  = 2'b10,
    MD_S_DONE = 2'b11
  } md_state_e;

  // One quotient bit is produced per DIV cycle.
  localparam int MD_DIV_ITERS = 32;
  localparam int MD_CNT_W     = $clog2(MD_DIV_ITERS);

  // Two's-complement negate when requested; wraps at 32 bits so that
  // the magnitude of 0x80000000 stays 0x80000000.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module muldiv_div_step (
  input  logic [32:0] rem,
  input  logic        shift_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic        q_bit
);

  // One extra bit over the shifted remainder so the borrow is unambiguous.
  logic [33:0] rem_shift;
  logic [33:0] trial;

  assign rem_shift = {rem, shift_bit};
  assign trial     = rem_shift - {2'b00, divisor};
  assign q_bit     = ~trial[33];
  assign rem_next  = q_bit ? trial[32:0] : rem_shift[32:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing one HI/LO write strobe
// per completed (non-cancelled) operation.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        write_hi,
  output logic        write_lo,
  output logic [31:0] write_hi_value,
  output logic [31:0] write_lo_value
);

  md_state_e             state_reg, state_next;
  logic [31:0]           a_reg, b_reg;
  logic [32:0]           rem_reg;
  logic [31:0]           quo_reg;
  logic [MD_CNT_W-1:0]   cnt_reg;
  logic                  mul_signed_reg, sign_q_reg, sign_r_reg;
  logic [31:0]           hi_reg, lo_reg;

  logic                  accept, op_is_div, op_signed, div_last;
  logic [31:0]           a_mag, b_mag, quo_next;
  logic [32:0]           rem_next;
  logic                  q_bit;
  logic [63:0]           prod_s, prod_u, product;

  // New requests are only taken while the unit is not busy.
  assign accept    = start && !cancel && (state_reg == MD_S_IDLE || state_reg == MD_S_DONE);
  assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign a_mag     = neg_if(op_signed && src_a[31], src_a);
  assign b_mag     = neg_if(op_signed && src_b[31], src_b);
  assign div_last  = (cnt_reg == MD_CNT_W'(MD_DIV_ITERS - 1));

  // Full-width product of the latched operands.
  assign prod_s  = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
  assign prod_u  = {32'd0, a_reg} * {32'd0, b_reg};
  assign product = mul_signed_reg ? prod_s : prod_u;

  // quo_reg doubles as the dividend shift register; quotient bits enter at the bottom.
  muldiv_div_step u_div_step (
    .rem       (rem_reg),
    .shift_bit (quo_reg[31]),
    .divisor   (b_reg),
    .rem_next  (rem_next),
    .q_bit     (q_bit)
  );
  assign quo_next = {quo_reg[30:0], q_bit};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= MD_S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; cancel always wins and returns to IDLE.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      MD_S_IDLE, MD_S_DONE:
        state_next = accept ? (op_is_div ? MD_S_DIV : MD_S_MUL) : MD_S_IDLE;
      MD_S_MUL:
        state_next = MD_S_DONE;
      MD_S_DIV:
        if (div_last) state_next = MD_S_DONE;
      default:
        state_next = MD_S_IDLE;
    endcase
    if (cancel) state_next = MD_S_IDLE;
  end

  // Operand latch, divide iterations and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg          <= '0;
      b_reg          <= '0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      cnt_reg        <= '0;
      mul_signed_reg <= 1'b0;
      sign_q_reg     <= 1'b0;
      sign_r_reg     <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
    end else if (accept) begin
      a_reg          <= src_a;
      b_reg          <= op_is_div ? b_mag : src_b;
      rem_reg        <= '0;
      quo_reg        <= a_mag;
      cnt_reg        <= '0;
      mul_signed_reg <= op_signed;
      sign_q_reg     <= op_signed && (src_a[31] ^ src_b[31]);
      sign_r_reg     <= op_signed && src_a[31];
    end else if (state_reg == MD_S_MUL) begin
      if (!cancel) {hi_reg, lo_reg} <= product;
    end else if (state_reg == MD_S_DIV) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (div_last && !cancel) begin
        hi_reg <= neg_if(sign_r_reg, rem_next[31:0]);
        lo_reg <= neg_if(sign_q_reg, quo_next);
      end
    end
  end

  assign busy           = (state_reg == MD_S_MUL) || (state_reg == MD_S_DIV);
  assign write_hi       = (state_reg == MD_S_DONE) && !cancel;
  assign write_lo       = write_hi;
  assign write_hi_value = hi_reg;
  assign write_lo_value = lo_reg;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the PE core; the producer of the HI/LO write-back interface (write_hi/write_lo strobes plus values) consumed by the HI/LO register write stage. It accepts MULT/MULTU/DIV/DIVU from execute with a start pulse. It computes the 64-bit product or the quotient/remainder with fixed latency and reports busy so the pipeline can stall. It then issues exactly one HI/LO write strobe per completed operation, unless the operation is cancelled.

## Interface
Parameters: none. Opcode and state encodings come from pe_defs.vh.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only when the unit is in IDLE or DONE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand (dividend / multiplicand)
- src_b  in  32  rt operand (divisor / multiplier)
- cancel  in  1  flush from exception/branch logic; aborts the current operation
- busy  out  1  high in MUL and DIV states
- write_hi  out  1  HI write strobe, one cycle
- write_lo  out  1  LO write strobe, always equal to write_hi
- write_hi_value  out  32  HI result (product[63:32] / remainder)
- write_lo_value  out  32  LO result (product[31:0] / quotient)

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: when start=1 and cancel=0, latch op, src_a and src_b.
  - MULT/MULTU go to MUL.
  - DIV/DIVU go to DIV, with the iteration counter cleared.
- MUL: one cycle. Register the full 64-bit product, then go to DONE.
  - MULT is signed × signed; MULTU is unsigned × unsigned.
- DIV: 32 restoring iterations on operand magnitudes, one quotient bit per cycle.
  - Signed ops: take |a| and |b|; record sign_q = a[31]^b[31] and sign_r = a[31].
  - Leave for DONE after counter = 31.
- DONE: one cycle. Assert write_hi = write_lo = 1 with the results.
  - Signed division: negate the quotient if sign_q, negate the remainder if sign_r.
  - Next state: IDLE, or MUL/DIV if start is sampled in this cycle (back-to-back issue).
- cancel:
  - In MUL, DIV or DONE: next state is IDLE.
  - In DONE, cancel combinationally forces write_hi = write_lo = 0 in the same cycle.
  - A start in the same cycle as cancel is ignored.
- A start while busy=1 is ignored; execute must hold the instruction while busy.
- Division by zero:
  - Quotient = 0xFFFFFFFF (unsigned magnitude) and remainder = dividend magnitude, then the signed fix-up applies.
  - The result is deterministic; no exception is raised.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0.
  - This falls out of 32-bit wrap in the negate.
- write_hi_value and write_lo_value hold the last result outside DONE. They are meaningful only while the strobes are high.

## Timing
- Reset: state IDLE; busy, write_hi and write_lo are 0; write_hi_value, write_lo_value and all internal registers are 0.
- Reset mid-operation discards the operation; no strobe is issued.
- Latency counts from the start cycle T to the strobe cycle.
  - MULT/MULTU: strobe at T+2; busy high at T+1 only.
  - DIV/DIVU: strobe at T+34 (DIV T+1..T+32, then a registered DONE at T+33 with the strobe at T+34?). This is not permitted; the decided rule is: DIV occupies T+1..T+32, DONE is T+33, and the strobe is at T+33. busy is high T+1..T+32.
  - The MUL latency is restated on the same basis: MUL is T+1, DONE is T+2, and the strobe is at T+2.
- Back-to-back: a start during DONE at cycle D gives the next strobe at D+2 (mult) or D+33 (div).
- busy is low in DONE, so issue has no bubble.
- All outputs are driven from registered state, except the cancel gating of the strobes.

## Structure
- pe_defs.vh holds:
  - the op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state encodings MD_IDLE, MD_MUL, MD_DIV, MD_DONE;
  - the iteration count constant MD_DIV_ITERS = 32.
- pe_undefs.vh undefines all of the above.
- One sub-module, muldiv_div_step: a combinational single restoring step.
  - Inputs: partial remainder (33-bit), dividend shift bit, divisor.
  - Outputs: next remainder and quotient bit.
  - It is instantiated once and driven by the DIV state registers.
- The multiplier is an inferred 64-bit product, registered in MUL.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> strobe at T+2, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; MULTU with the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 -> busy for 32 cycles, strobe at T+33, LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1); DIVU 100/7 -> LO = 14, HI = 2.
- DIVU 0x12345678 / 0 -> LO = 0xFFFFFFFF, HI = 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIV started, cancel asserted at T+10 -> IDLE at T+11, busy = 0, no strobe ever; cancel in the DONE cycle -> strobe suppressed that cycle.
- Start in the DONE cycle of a DIV, issuing MULTU 5 × 6 -> a strobe for the div, then 2 cycles later a strobe with HI = 0, LO = 30; a start while busy is ignored (no extra strobe).
- rst asserted at T+5 of a DIV -> all outputs 0 on the next cycle, state IDLE, no strobe; a fresh MULT 2 × 3 afterwards -> LO = 6.
